// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: parametrised chain of control-bundle pipeline registers
// with per-stage stall (propagating backwards), flush, in_ready and retire count.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   in_valid, in_ctrl bundle offered to stage 0 by the control-unit mux
//   in_ready          stage 0 can accept a bundle this cycle
//   stall, flush      per-stage hold request / bubble-insert request
//   stage_valid       valid bit of each stage
//   stage_ctrl        stage i bundle at [i*W +: W]
//   retire_count      valid bundles that left the last stage (wraps)
module ctrl_pipe_chain #(
    parameter int             STAGES = 4,
    parameter int             W      = 8,
    parameter logic [W-1:0]   BUBBLE = '0,
    parameter int             CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [W-1:0]        in_ctrl,
    output logic                in_ready,
    input  logic [STAGES-1:0]   stall,
    input  logic [STAGES-1:0]   flush,
    output logic [STAGES-1:0]   stage_valid,
    output logic [STAGES*W-1:0] stage_ctrl,
    output logic [CNT_W-1:0]    retire_count
);

    // hold[i] is set when stage i or any later stage stalls; computed
    // as an OR-reduction of the shifted stall vector to stay loop-free.
    logic [STAGES-1:0] hold;

    always_comb begin
        hold = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    assign in_ready = ~hold[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic         v;
        logic [W-1:0] c;

        if (i == 0) begin : g_head
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v <= 1'b0;
                    c <= BUBBLE;
                end else if (flush[i]) begin
                    v <= 1'b0;
                    c <= BUBBLE;
                end else if (!hold[i]) begin
                    v <= in_valid;
                    c <= in_valid ? in_ctrl : BUBBLE;
                end
            end
        end else begin : g_body
            // Upstream stage held: it keeps its bundle, so this slot
            // must become a bubble to avoid duplicating it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v <= 1'b0;
                    c <= BUBBLE;
                end else if (flush[i]) begin
                    v <= 1'b0;
                    c <= BUBBLE;
                end else if (!hold[i]) begin
                    if (hold[i-1]) begin
                        v <= 1'b0;
                        c <= BUBBLE;
                    end else begin
                        v <= g_stage[i-1].v;
                        c <= g_stage[i-1].c;
                    end
                end
            end
        end

        assign stage_valid[i]       = v;
        assign stage_ctrl[i*W +: W] = c;
    end

    // A flush of the last stage does not cancel the bundle leaving it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (stage_valid[STAGES-1] && !hold[STAGES-1]) begin
            retire_count <= retire_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: scoreboard bench for ctrl_pipe_chain (4 stages,
// 8-bit bundles, 4-bit retire counter so the wrap is reachable).
module tb_ctrl_pipe_chain;

    localparam int S  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [W-1:0]    in_ctrl;
    logic            in_ready;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic [S-1:0]    stage_valid;
    logic [S*W-1:0]  stage_ctrl;
    logic [CW-1:0]   retire_count;

    ctrl_pipe_chain #(
        .STAGES(S),
        .W(W),
        .BUBBLE(8'h00),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ctrl(in_ctrl),
        .in_ready(in_ready),
        .stall(stall),
        .flush(flush),
        .stage_valid(stage_valid),
        .stage_ctrl(stage_ctrl),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sbq[$];
    logic [3:0]  exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sc(input int i);
        return stage_ctrl[i*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive stage-0 inputs; a bundle that will be accepted is queued.
    task automatic drive(input logic v, input logic [7:0] c);
        in_valid = v;
        in_ctrl  = c;
        #1;
        if (v && in_ready) sbq.push_back(c);
    endtask

    task automatic drain(input int n);
        drive(1'b0, 8'hEE);
        for (int k = 0; k < n; k++) step();
    endtask

    // Monitor: a bundle in the last stage with no stall there retires
    // at the coming edge; compare it against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            exp_cnt = '0;
        end else begin
            chk("retire_count", 32'(retire_count), 32'(exp_cnt));
            for (int i = 0; i < S; i++) begin
                if (!stage_valid[i]) chk("bubble_norm", 32'(sc(i)), 32'h0);
            end
            if (stage_valid[S-1] && !stall[S-1]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected: got %0h required none",
                             sc(S-1));
                end else begin
                    chk("retire_ctrl", 32'(sc(S-1)), 32'(sbq.pop_front()));
                    exp_cnt = exp_cnt + 1'b1;
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        stall    = '0;
        flush    = '0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        #1;
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_ctrl", stage_ctrl, 32'h0);
        chk("rst_count", 32'(retire_count), 32'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'h1);

        // Streaming
        drive(1'b1, 8'h11); step();
        drive(1'b1, 8'h22); step();
        drive(1'b1, 8'h33); step();
        drive(1'b0, 8'hEE); step();
        chk("s2_e4_ctrl3", 32'(sc(3)), 32'h11);
        chk("s2_e4_v3", 32'(stage_valid[3]), 32'h1);
        step();
        chk("s2_e5_ctrl3", 32'(sc(3)), 32'h22);
        chk("s2_e5_count", 32'(retire_count), 32'h1);
        step();
        step();
        chk("s2_e7_count", 32'(retire_count), 32'h3);
        chk("s2_e7_valid", 32'(stage_valid), 32'h0);
        chk("s2_e7_ctrl", stage_ctrl, 32'h0);

        // Stall of stage 1 for two edges
        drive(1'b1, 8'hA1); step();
        drive(1'b1, 8'hA2); step();
        drive(1'b1, 8'hA3); step();
        stall = 4'b0010;
        drive(1'b1, 8'hA4);
        chk("s3_ready", 32'(in_ready), 32'h0);
        step();
        chk("s3_e1_ctrl", stage_ctrl, 32'hA1_00_A2_A3);
        chk("s3_e1_valid", 32'(stage_valid), 32'hB);
        step();
        chk("s3_e2_ctrl", stage_ctrl, 32'h00_00_A2_A3);
        chk("s3_e2_valid", 32'(stage_valid), 32'h3);
        stall = 4'b0000;
        drive(1'b1, 8'hA4); step();
        chk("s3_resume_ctrl", stage_ctrl, 32'h00_A2_A3_A4);
        chk("s3_resume_valid", 32'(stage_valid), 32'h7);
        drain(5);
        chk("s3_count", 32'(retire_count), 32'h7);

        // Flush priority over hold
        drive(1'b1, 8'hB1); step();
        drive(1'b1, 8'hB2); step();
        drive(1'b1, 8'hB3); step();
        drive(1'b1, 8'hB4); step();
        stall = 4'b0100;
        flush = 4'b0011;
        drive(1'b0, 8'hEE);
        step();
        chk("s4_ctrl", stage_ctrl, 32'h00_B2_00_00);
        chk("s4_valid", 32'(stage_valid), 32'h4);
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        stall = 4'b0000;
        flush = 4'b0000;
        drain(3);
        chk("s4_count", 32'(retire_count), 32'h9);

        // Asynchronous reset between edges with data in flight
        drive(1'b1, 8'hC1); step();
        drive(1'b1, 8'hC2); step();
        drive(1'b0, 8'hEE);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(stage_valid), 32'h0);
        chk("mid_rst_ctrl", stage_ctrl, 32'h0);
        chk("mid_rst_count", 32'(retire_count), 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'h1);

        // Counter wrap: 17 bundles with bubbles between them
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(8'h40 + i)); step();
            drive(1'b0, 8'hEE); step();
        end
        drain(4);
        chk("s5_wrap", 32'(retire_count), 32'h1);

        // Last-stage stall freezes the whole chain
        drive(1'b1, 8'hD1); step();
        drive(1'b1, 8'hD2); step();
        drive(1'b1, 8'hD3); step();
        drive(1'b1, 8'hD4); step();
        stall = 4'b1000;
        drive(1'b0, 8'hEE);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s6_ctrl", stage_ctrl, 32'hD1_D2_D3_D4);
            chk("s6_valid", 32'(stage_valid), 32'hF);
            chk("s6_count", 32'(retire_count), 32'h1);
            chk("s6_ready", 32'(in_ready), 32'h0);
        end
        stall = 4'b0000;
        #1;
        step();
        chk("s6_release", 32'(retire_count), 32'h2);
        drain(4);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        chk("final_count", 32'(retire_count), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised chain of control-signal pipeline registers. It replaces the fixed ID/EX, EX/MEM and MEM/WB control registers with one block of STAGES stages, each carrying a W-bit control bundle plus a valid bit. Adds features the fixed registers lack: per-stage stall with backward propagation, per-stage flush (bubble insertion), an input-ready handshake and a retired-bundle counter. Sits between the control-unit mux and the datapath stage consumers.

Parameters:
STAGES, 4, number of pipeline stages (>=2); stage 0 is fed from ID, stage STAGES-1 is WB.
W, 8, control bundle width (RegWrite, MemWrite, MemtoReg, ALUSrc, ALUControl, S, PCSrc).
BUBBLE, {W{1'b0}}, control value loaded for an invalid/bubble slot; must encode no writes.
CNT_W, 16, width of retired-bundle counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  bundle at in_ctrl is a real instruction
in_ctrl  in  W  control bundle from control-unit mux
in_ready  out  1  stage 0 accepts a new bundle this cycle
stall  in  STAGES  stall[i] requests stage i hold its contents
flush  in  STAGES  flush[i] forces stage i to load a bubble at this edge
stage_valid  out  STAGES  valid bit of each stage register
stage_ctrl  out  STAGES*W  stage i bundle at bits [i*W +: W]
retire_count  out  CNT_W  number of valid bundles retired from the last stage

Behaviour:
- Reset (async, immediate, no edge needed): stage_valid=0, every stage_ctrl=BUBBLE, retire_count=0. in_ready=1 provided stall=0.
- Effective hold, combinational: hold[STAGES-1]=stall[STAGES-1]; hold[i]=stall[i] | hold[i+1]. A stalled stage freezes all earlier stages.
- in_ready = ~hold[0]. It is combinational from stall and does not depend on flush.
- Per-stage update at each rising clk edge, evaluated in priority order:
  1. flush[i]=1: valid<=0, ctrl<=BUBBLE. Flush wins over hold.
  2. hold[i]=1: register keeps its value.
  3. i=0: valid<=in_valid, ctrl<=in_valid ? in_ctrl : BUBBLE.
  4. i>0 and hold[i-1]=1: bubble inserted (valid<=0, ctrl<=BUBBLE).
  5. Otherwise: stage i takes stage i-1's pre-edge valid/ctrl.
- A flush of stage i-1 does not affect what stage i receives at the same edge. Stage i takes the old contents of stage i-1.
- Invalid bundles are always normalised to BUBBLE; a stage with valid=0 never holds a non-BUBBLE ctrl.
- Latency with no stalls or flushes: a bundle accepted at edge k appears in stage j after edge k+j. It is visible in the last stage after STAGES edges from acceptance.
- Retire: at an edge where stage_valid[STAGES-1]=1 and hold[STAGES-1]=0, retire_count<=retire_count+1, modulo 2^CNT_W (wraps, no saturation).
  - A flush of the last stage at that edge still counts the retiring bundle.
  - A bubble never counts.
- When all stages stall simultaneously, the whole chain is frozen and the counter does not increment.
- Stall/flush inputs are sampled only at edges. Glitches between edges have no effect except on in_ready.

Test Plan:
1. Reset: assert reset mid-simulation with no clock edge. Required: stage_valid=0000, stage_ctrl all 0x00 and retire_count=0 immediately. After release with stall=0, in_ready=1.
2. Streaming (STAGES=4, W=8): in_valid=1 with 0x11, 0x22, 0x33 on consecutive edges, then in_valid=0.
   - After edge 4: stage3=0x11, valid.
   - After edge 5: stage3=0x22 and retire_count=1.
   - After edge 7: retire_count=3 and all stages drain to BUBBLE.
3. Stall: stream 0xA1.. and hold stall[1]=1 for 2 edges.
   - Required: in_ready=0; stages 0 and 1 frozen.
   - Stage 2 loads bubbles (valid 0, ctrl 0x00) on both edges, while stage 3 keeps advancing.
   - Flow resumes without loss or duplication.
4. Flush priority: with stall[2]=1 and flush[0]=flush[1]=1 for one edge.
   - Required: stages 0 and 1 become bubble, stage 2 holds its value, stage 3 loads a bubble.
5. Counter wrap (CNT_W=4): retire 17 valid bundles. Required: retire_count=1. Bubbles interleaved via in_valid=0 do not increment the count.
6. Last-stage stall: stall[3]=1 with stage 3 valid for 3 edges. Required: retire_count unchanged, all stages frozen, in_ready=0. Releasing the stall increments the count by 1 at the next edge.
